uart_axis_rx: RTL

UART_AXIS_RX -- requirements
Module: uart_axis_rx

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_axis_rx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and receiver state type for the UART-to-stream receiver
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage array; contents are don't-care until written, reads are masked by empty upstream
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_axis_rx.sv
// rtl/uart_axis_rx.sv - UART receiver delivering idle-delimited packets on a stream interface
module uart_axis_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int IDLE_BITS    = 10,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int HALF_BIT   = CLKS_PER_BIT / 2;
    localparam int IDLE_TERM  = IDLE_BITS * CLKS_PER_BIT;
    localparam int BIT_CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDLE_CNT_W = $clog2(IDLE_TERM + 1);
    localparam int BIT_IDX_W  = $clog2(DATA_BITS);

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]  HALF_LAST = BIT_CNT_W'(HALF_BIT - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_TERM);
    localparam logic [BIT_IDX_W-1:0]  IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    logic                  rx_sync1;
    logic                  rx_sync2;
    logic                  rx_prev;
    logic [1:0]            sync_fill;
    logic                  armed;
    logic                  start_edge;

    rx_state_e             state;
    logic [BIT_CNT_W-1:0]  clk_cnt;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  pend_valid;
    logic [DATA_BITS-1:0]  pend_data;
    logic                  push_en;
    logic [DATA_BITS:0]    push_data;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_BITS:0]    fifo_rd_data;
    logic                  pop;

    assign start_edge = rx_prev && !rx_sync2;
    assign pop        = m_axis_tvalid && m_axis_tready;

    // Two-flop synchronizer plus one delayed copy for edge detection; sync_fill marks
    // when rx_sync2 carries a real line sample rather than its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1  <= 1'b1;
            rx_sync2  <= 1'b1;
            rx_prev   <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_sync1  <= uart_rx;
            rx_sync2  <= rx_sync1;
            rx_prev   <= rx_sync2;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    // Receive FSM with staging register and idle timer; push/frame_err are one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            idle_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            push_en    <= 1'b0;
            push_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            push_en   <= 1'b0;
            frame_err <= 1'b0;
            if (sync_fill[1] && rx_sync2) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (armed && start_edge) begin
                        state    <= START;
                        clk_cnt  <= '0;
                        idle_cnt <= '0;
                    end else begin
                        if (idle_cnt != IDLE_LAST) begin
                            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
                        end
                        // Line quiet long enough: the staged byte closes the packet
                        if (pend_valid && idle_cnt == IDLE_LAST) begin
                            push_en    <= 1'b1;
                            push_data  <= {1'b1, pend_data};
                            pend_valid <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        // High at mid start bit means a glitch, not a frame
                        if (rx_sync2) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + BIT_CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_sync2, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + BIT_CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_sync2) begin
                            // Another byte followed, so the staged one is not the last
                            if (pend_valid) begin
                                push_en   <= 1'b1;
                                push_data <= {1'b0, pend_data};
                            end
                            pend_valid <= 1'b1;
                            pend_data  <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                            if (pend_valid) begin
                                push_en    <= 1'b1;
                                push_data  <= {1'b1, pend_data};
                                pend_valid <= 1'b0;
                            end
                        end
                    end else begin
                        clk_cnt <= clk_cnt + BIT_CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flag a push the FIFO had to drop because it was full and nothing was popped
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= push_en && fifo_full && !pop;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_en),
        .wr_data (push_data),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = m_axis_tvalid ? fifo_rd_data[DATA_BITS-1:0] : '0;
    assign m_axis_tlast  = m_axis_tvalid ? fifo_rd_data[DATA_BITS] : 1'b0;

endmodule
